// File: rtl/vga_if.sv
// vga_if: raster timing and pixel coordinate bundle from the timing generator to the DAC/color path.
interface vga_if;
   logic       VGA_CLK;
   logic       VGA_HS;
   logic       VGA_VS;
   logic       VGA_BLANK_N;
   logic       VGA_SYNC_N;
   logic [9:0] DrawX;
   logic [9:0] DrawY;
   logic       pixel_en;
   logic       frame_start;
   modport master (output VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, DrawX, DrawY, pixel_en, frame_start);
   modport slave (input VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, DrawX, DrawY, pixel_en, frame_start);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running raster counters with a divide-by-2 pixel enable and registered syncs.
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33
) (
   input  logic Clk,
   input  logic Reset,
   vga_if.master vga
);
   localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
   localparam logic [9:0] HS_ON  = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] HS_OFF = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_ON  = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] VS_OFF = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
   logic       div_q;
   logic [9:0] h_q, h_d, v_q, v_d;
   logic       hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
   // Syncs and blank derive from the next counters so they line up with DrawX/DrawY.
   always_comb begin
      h_d       = div_q ? ((h_q == H_LAST) ? 10'd0 : h_q + 10'd1) : h_q;
      v_d       = (div_q && h_q == H_LAST) ? ((v_q == V_LAST) ? 10'd0 : v_q + 10'd1) : v_q;
      hs_d      = !(h_d >= HS_ON && h_d <= HS_OFF);
      vs_d      = !(v_d >= VS_ON && v_d <= VS_OFF);
      blank_n_d = (h_d < H_VIS) && (v_d < V_VIS);
   end
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         div_q     <= 1'b0;
         h_q       <= 10'd0;
         v_q       <= 10'd0;
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
         blank_n_q <= 1'b1;
      end else begin
         div_q     <= ~div_q;
         h_q       <= h_d;
         v_q       <= v_d;
         hs_q      <= hs_d;
         vs_q      <= vs_d;
         blank_n_q <= blank_n_d;
      end
   end
   assign vga.VGA_CLK     = div_q;
   assign vga.pixel_en    = div_q;
   assign vga.VGA_HS      = hs_q;
   assign vga.VGA_VS      = vs_q;
   assign vga.VGA_BLANK_N = blank_n_q;
   assign vga.VGA_SYNC_N  = 1'b0;
   assign vga.DrawX       = h_q;
   assign vga.DrawY       = v_q;
   assign vga.frame_start = (h_q == 10'd0) && (v_q == 10'd0) && !div_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of a full-size instance (line timing) and a shrunken
// instance (15x8 raster, 240 Clk per frame) for frame, wrap and mid-frame reset behaviour.
module tb_vga_timing_gen;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   passed = 0;
   int   inv_err = 0;
   int   ex_x[4]  = '{0, 0, 1, 1};
   int   ex_pe[4] = '{0, 1, 0, 1};
   int   ex_fs[4] = '{1, 0, 0, 0};
   vga_if d_if ();
   vga_if s_if ();
   vga_timing_gen u_d (.Clk(clk), .Reset(rst), .vga(d_if));
   vga_timing_gen #(
      .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
   ) u_s (.Clk(clk), .Reset(rst), .vga(s_if));
   always #5 clk = ~clk;
   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask
   task automatic step();
      @(negedge clk);
      if (d_if.VGA_SYNC_N !== 1'b0 || s_if.VGA_SYNC_N !== 1'b0 ||
          d_if.DrawX >= 800 || d_if.DrawY >= 525 || s_if.DrawX >= 15 || s_if.DrawY >= 8 ||
          ((d_if.VGA_HS === 1'b0 || d_if.VGA_VS === 1'b0) && d_if.VGA_BLANK_N !== 1'b0) ||
          ((s_if.VGA_HS === 1'b0 || s_if.VGA_VS === 1'b0) && s_if.VGA_BLANK_N !== 1'b0))
         inv_err++;
   endtask
   task automatic rst_state(input string p);
      chk({p, "_dx"}, int'(d_if.DrawX), 0);
      chk({p, "_dy"}, int'(d_if.DrawY), 0);
      chk({p, "_hs"}, int'(d_if.VGA_HS), 1);
      chk({p, "_vs"}, int'(d_if.VGA_VS), 1);
      chk({p, "_blank"}, int'(d_if.VGA_BLANK_N), 1);
      chk({p, "_fs"}, int'(d_if.frame_start), 1);
      chk({p, "_pe"}, int'(d_if.pixel_en), 0);
      chk({p, "_sx"}, int'(s_if.DrawX), 0);
      chk({p, "_sy"}, int'(s_if.DrawY), 0);
      chk({p, "_shs"}, int'(s_if.VGA_HS), 1);
      chk({p, "_svs"}, int'(s_if.VGA_VS), 1);
      chk({p, "_sfs"}, int'(s_if.frame_start), 1);
   endtask
   initial begin
      int n, low, px, py, bad;
      #12;
      rst_state("in_reset");
      chk("in_reset_sync_n", int'(d_if.VGA_SYNC_N), 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step();
         chk($sformatf("start_x%0d", i), int'(d_if.DrawX), ex_x[i]);
         chk($sformatf("start_pe%0d", i), int'(d_if.pixel_en), ex_pe[i]);
         chk($sformatf("start_clk%0d", i), int'(d_if.VGA_CLK), ex_pe[i]);
         chk($sformatf("start_fs%0d", i), int'(d_if.frame_start), ex_fs[i]);
      end
      n = 0;
      while (d_if.VGA_BLANK_N !== 1'b0 && n < 2000) begin step(); n++; end
      chk("blank_fall_x", int'(d_if.DrawX), 640);
      chk("blank_fall_y", int'(d_if.DrawY), 0);
      n = 0;
      while (d_if.VGA_HS !== 1'b0 && n < 2000) begin step(); n++; end
      chk("hs_fall_x", int'(d_if.DrawX), 656);
      low = 0;
      while (d_if.VGA_HS === 1'b0 && low < 400) begin step(); low++; end
      chk("hs_low_clk", low, 192);
      chk("hs_rise_x", int'(d_if.DrawX), 752);
      n = 0;
      px = -1;
      py = -1;
      while (d_if.VGA_BLANK_N !== 1'b1 && n < 2000) begin
         px = int'(d_if.DrawX);
         py = int'(d_if.DrawY);
         step();
         n++;
      end
      chk("line_end_x", px, 799);
      chk("line_end_y", py, 0);
      chk("blank_rise_x", int'(d_if.DrawX), 0);
      chk("blank_rise_y", int'(d_if.DrawY), 1);
      n = 0;
      while (s_if.frame_start !== 1'b1 && n < 400) begin
         px = int'(s_if.DrawX);
         py = int'(s_if.DrawY);
         step();
         n++;
      end
      chk("wrap_prev_x", px, 14);
      chk("wrap_prev_y", py, 7);
      chk("wrap_x", int'(s_if.DrawX), 0);
      chk("wrap_y", int'(s_if.DrawY), 0);
      chk("wrap_blank", int'(s_if.VGA_BLANK_N), 1);
      chk("wrap_hs", int'(s_if.VGA_HS), 1);
      chk("wrap_vs", int'(s_if.VGA_VS), 1);
      step();
      chk("fs_one_cycle", int'(s_if.frame_start), 0);
      n = 1;
      low = 0;
      bad = 0;
      while (s_if.frame_start !== 1'b1 && n < 400) begin
         if (s_if.VGA_BLANK_N !== (s_if.DrawX < 8 && s_if.DrawY < 4)) bad++;
         if (s_if.VGA_HS !== !(s_if.DrawX >= 10 && s_if.DrawX <= 12)) bad++;
         if (s_if.VGA_VS !== !(s_if.DrawY >= 5 && s_if.DrawY <= 6)) bad++;
         if (s_if.VGA_VS === 1'b0) low++;
         step();
         n++;
      end
      chk("frame_period", n, 240);
      chk("vs_low_clk", low, 60);
      chk("frame_sync_model_errs", bad, 0);
      n = 0;
      while (!(s_if.DrawX == 5 && s_if.DrawY == 2) && n < 400) begin step(); n++; end
      chk("mid_reset_x", int'(s_if.DrawX), 5);
      #2 rst = 1'b1;
      #1;
      rst_state("mid_reset");
      @(negedge clk);
      rst = 1'b0;
      chk("release_fs", int'(s_if.frame_start), 1);
      step();
      n = 1;
      while (s_if.frame_start !== 1'b1 && n < 400) begin step(); n++; end
      chk("post_reset_period", n, 240);
      chk("invariants", inv_err, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
